farbborg_scan_reader: RTL and testbench

- Read-side scan engine for the farbborg frame buffer: 128 words x 64 bit, 8 brightness bytes per word.
- Walks the buffer's 7-bit read port plane by plane and turns each byte into a PWM on/off bit by comparing it with a global PWM counter.
- Shifts the result into the external LED column shift registers on 8 parallel lanes, latches it, and drives a one-hot plane select.
- Sits between the frame buffer read port and the LED driver pins; the Wishbone write side is untouched.

---
 rtl/farbborg_pkg.sv | 35 +++
 rtl/farbborg_lane_cmp.sv | 68 ++++++
 rtl/farbborg_scan_reader.sv | 156 +++++++++++++++
 tb/tb_farbborg_scan_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/farbborg_pkg.sv
// farbborg_pkg - shared types and constants for the farbborg scan reader.
//
// Contents:
//   scan_state_t  scan FSM state encoding (WAIT2 is only reachable when
//                 FARBBORG_GAMMA_EN is defined)
//   PLANES, WORDS_PER_PLANE, LANES, BYTE_W  frame buffer geometry
//   compose_addr  builds the read address {plane, word}
package farbborg_pkg;

   localparam int PLANES          = 8;
   localparam int WORDS_PER_PLANE = 16;
   localparam int LANES           = 8;
   localparam int BYTE_W          = 8;

   localparam int PLANE_W = 3;
   localparam int WORD_W  = 4;
   localparam int ADDR_W  = PLANE_W + WORD_W;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WAIT2,
      SH_HI,
      SH_LO,
      LATCH,
      SHOW
   } scan_state_t;

   function automatic logic [ADDR_W-1:0] compose_addr(input logic [PLANE_W-1:0] plane,
                                                      input logic [WORD_W-1:0]  word);
      return {plane, word};
   endfunction

endpackage

// File: rtl/farbborg_lane_cmp.sv
// farbborg_lane_cmp - turns one 64-bit frame buffer word into 8 PWM bits.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      1 in the cycle where word holds valid read data
//   word      8 brightness bytes, lane i = word[8i+7:8i]
//   pwm_cnt   global PWM counter
//   sdat      registered PWM bits, lane i on when its level exceeds pwm_cnt
//
// FARBBORG_GAMMA_EN: when defined, each byte is squared (b*b >> 8) and the
// square is registered first, so sdat updates one cycle after load.
module farbborg_lane_cmp
   import farbborg_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [LANES*BYTE_W-1:0]   word,
   input  logic [BYTE_W-1:0]         pwm_cnt,
   output logic [LANES-1:0]          sdat
);

`ifdef FARBBORG_GAMMA_EN
   function automatic logic [BYTE_W-1:0] gamma_sq(input logic [BYTE_W-1:0] b);
      logic [2*BYTE_W-1:0] sq;
      sq = {{BYTE_W{1'b0}}, b} * {{BYTE_W{1'b0}}, b};
      return sq[2*BYTE_W-1:BYTE_W];
   endfunction

   logic [LANES-1:0][BYTE_W-1:0] g_p1;
   logic                         vld_p1;

   // stage p0 -> p1: square each lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g_p1   <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= load;
         if (load) begin
            for (int i = 0; i < LANES; i++)
               g_p1[i] <= gamma_sq(word[i*BYTE_W +: BYTE_W]);
         end
      end
   end

   // stage p1 -> output: compare squared level with the PWM counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdat <= '0;
      end else if (vld_p1) begin
         for (int i = 0; i < LANES; i++)
            sdat[i] <= (g_p1[i] > pwm_cnt);
      end
   end
`else
   // stage p0 -> output: linear compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdat <= '0;
      end else if (load) begin
         for (int i = 0; i < LANES; i++)
            sdat[i] <= (word[i*BYTE_W +: BYTE_W] > pwm_cnt);
      end
   end
`endif

endmodule

// File: rtl/farbborg_scan_reader.sv
// farbborg_scan_reader - read-side scan engine for the farbborg frame buffer.
//
// Walks the 128 x 64 bit buffer plane by plane, converts every byte into a
// PWM bit, shifts 16 words per plane into the LED column registers on 8
// lanes, latches, then shows the plane for DWELL cycles.
//
// Ports:
//   clk_i     system clock (also clocks the buffer read port)
//   rst_i     asynchronous active-high reset
//   enable_i  scan enable, level-sensitive, checked in IDLE and at plane end
//   addrb_o   buffer read address {plane, word}
//   dob_i     read data, valid one cycle after addrb_o
//   sdat_o    shift data, one PWM bit per lane
//   sclk_o    shift clock, rising edge samples sdat_o
//   latch_o   one-cycle latch strobe
//   oe_n_o    driver output enable, active low
//   plane_o   one-hot plane select, non-zero only while showing
//   frame_o   pulse on the first read of plane 0 with pwm_cnt = 0
//
// FARBBORG_GAMMA_EN: squared brightness compare with one extra WAIT2 cycle
// per word (5 cycles per word instead of 4).
module farbborg_scan_reader
   import farbborg_pkg::*;
#(
   parameter int DWELL   = 64,
   parameter int PWM_TOP = 254
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   output logic [ADDR_W-1:0]        addrb_o,
   input  logic [LANES*BYTE_W-1:0]  dob_i,
   output logic [LANES-1:0]         sdat_o,
   output logic                     sclk_o,
   output logic                     latch_o,
   output logic                     oe_n_o,
   output logic [PLANES-1:0]        plane_o,
   output logic                     frame_o
);

   localparam logic [15:0]       DWELL_LAST = 16'(DWELL - 1);
   localparam logic [BYTE_W-1:0] PWM_LAST   = BYTE_W'(PWM_TOP);
   localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(WORDS_PER_PLANE - 1);
   localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

   scan_state_t          state, state_nx;
   logic [PLANE_W-1:0]   plane, plane_nx;
   logic [WORD_W-1:0]    word, word_nx;
   logic [BYTE_W-1:0]    pwm_cnt, pwm_nx;
   logic [15:0]          dwell_cnt, dwell_nx;

   logic [ADDR_W-1:0]    addrb_nx;
   logic                 sclk_nx, latch_nx, oe_n_nx, frame_nx;
   logic [PLANES-1:0]    plane_sel_nx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         plane     <= '0;
         word      <= '0;
         pwm_cnt   <= '0;
         dwell_cnt <= '0;
         addrb_o   <= '0;
         sclk_o    <= 1'b0;
         latch_o   <= 1'b0;
         oe_n_o    <= 1'b1;
         plane_o   <= '0;
         frame_o   <= 1'b0;
      end else begin
         state     <= state_nx;
         plane     <= plane_nx;
         word      <= word_nx;
         pwm_cnt   <= pwm_nx;
         dwell_cnt <= dwell_nx;
         addrb_o   <= addrb_nx;
         sclk_o    <= sclk_nx;
         latch_o   <= latch_nx;
         oe_n_o    <= oe_n_nx;
         plane_o   <= plane_sel_nx;
         frame_o   <= frame_nx;
      end
   end

   always_comb begin
      state_nx = state;
      plane_nx = plane;
      word_nx  = word;
      pwm_nx   = pwm_cnt;
      dwell_nx = dwell_cnt;

      case (state)
         IDLE: begin
            if (enable_i) begin
               state_nx = READ;
               plane_nx = '0;
               word_nx  = '0;
               pwm_nx   = '0;
            end
         end
         READ: state_nx = WAIT;
`ifdef FARBBORG_GAMMA_EN
         WAIT: state_nx = WAIT2;
`else
         WAIT: state_nx = SH_HI;
`endif
         WAIT2: state_nx = SH_HI;
         SH_HI: state_nx = SH_LO;
         SH_LO: begin
            if (word == WORD_LAST) begin
               state_nx = LATCH;
               word_nx  = '0;
            end else begin
               state_nx = READ;
               word_nx  = word + WORD_W'(1);
            end
         end
         LATCH: begin
            state_nx = SHOW;
            dwell_nx = '0;
         end
         SHOW: begin
            if (dwell_cnt == DWELL_LAST) begin
               dwell_nx = '0;
               plane_nx = plane + PLANE_W'(1);
               // PWM advances once every full pass over the planes
               if (plane == PLANE_LAST)
                  pwm_nx = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + BYTE_W'(1);
               state_nx = enable_i ? READ : IDLE;
            end else begin
               dwell_nx = dwell_cnt + 16'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      addrb_nx     = (state_nx == READ) ? compose_addr(plane_nx, word_nx) : addrb_o;
      sclk_nx      = (state_nx == SH_HI);
      latch_nx     = (state_nx == LATCH);
      oe_n_nx      = (state_nx != SHOW);
      plane_sel_nx = (state_nx == SHOW) ? (PLANES'(1) << plane_nx) : '0;
      // A READ not coming from SH_LO is always the first word of a plane.
      frame_nx     = (state_nx == READ) && (state != SH_LO) &&
                     (plane_nx == '0) && (pwm_nx == '0);
   end

   farbborg_lane_cmp u_lane_cmp (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (state == WAIT),
      .word    (dob_i),
      .pwm_cnt (pwm_cnt),
      .sdat    (sdat_o)
   );

endmodule

// File: tb/tb_farbborg_scan_reader.sv
module tb_farbborg_scan_reader;

   localparam int DWELL   = 3;
   localparam int PWM_TOP = 11;
`ifdef FARBBORG_GAMMA_EN
   localparam int WC = 5;
`else
   localparam int WC = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [6:0]  addrb;
   logic [63:0] dob;
   logic [7:0]  sdat;
   logic        sclk, latch, oe_n, frame;
   logic [7:0]  plane;

   logic [63:0] mem [128];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int mon_on = 0;
   int m_plane, m_pwm, m_word, m_in_show, m_show_len, m_frame_seen;
   int m_cyc = 0, m_last_sclk = 0, m_planes = 0;

   always #5 clk = ~clk;

   // synchronous-read frame buffer
   always @(posedge clk) dob <= mem[addrb];

   farbborg_scan_reader #(.DWELL(DWELL), .PWM_TOP(PWM_TOP)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .addrb_o  (addrb),
      .dob_i    (dob),
      .sdat_o   (sdat),
      .sclk_o   (sclk),
      .latch_o  (latch),
      .oe_n_o   (oe_n),
      .plane_o  (plane),
      .frame_o  (frame)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected PWM bits for one word at a given PWM count.
   function automatic logic [7:0] ref_bits(input logic [63:0] w, input int pwm);
      logic [7:0] r;
      int b;
      for (int i = 0; i < 8; i++) begin
         b = int'(w[8*i +: 8]);
`ifdef FARBBORG_GAMMA_EN
         b = (b * b) / 256;
`endif
         r[i] = (b > pwm);
      end
      return r;
   endfunction

   // Event-level model: each sclk shifts the next word of the current plane,
   // each latch closes a plane, the show window must last DWELL cycles.
   task automatic mon_step();
      m_cyc++;
      if (mon_on == 0) begin
         m_plane = 0; m_pwm = 0; m_word = 0; m_in_show = 0; m_frame_seen = 0;
         return;
      end
      if (frame) m_frame_seen = 1;
      if (sclk) begin
         if (m_word == 0) begin
            chk("frame", m_frame_seen, (m_plane == 0 && m_pwm == 0));
            m_frame_seen = 0;
         end else begin
            chk("sclk_gap", m_cyc - m_last_sclk, WC);
         end
         m_last_sclk = m_cyc;
         chk("addrb", addrb, m_plane * 16 + m_word);
         chk("sdat", sdat, ref_bits(mem[(m_plane * 16 + m_word) % 128], m_pwm));
         m_word++;
      end
      if (latch) begin
         chk("shifts", m_word, 16);
         chk("latch_gap", m_cyc - m_last_sclk, 2);
         m_word = 0; m_in_show = 1; m_show_len = 0;
      end else if (m_in_show != 0) begin
         if (!oe_n) begin
            chk("plane_o", plane, 64'd1 << m_plane);
            m_show_len++;
         end else begin
            chk("dwell", m_show_len, DWELL);
            chk("plane_off", plane, 0);
            m_plane = (m_plane + 1) % 8;
            if (m_plane == 0) m_pwm = (m_pwm == PWM_TOP) ? 0 : m_pwm + 1;
            m_in_show = 0;
            m_planes++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon_step();
   endtask

   task automatic run_planes(input int n, input int budget);
      int target;
      int k;
      target = m_planes + n;
      k = 0;
      while (m_planes < target && k < budget) begin
         tick();
         k++;
      end
      chk("plane_budget", m_planes >= target, 1);
   endtask

   initial begin
      int k;
      int nsclk;
      rst = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = '0;
      repeat (3) tick();

      chk("rst_addrb", addrb, 0);
      chk("rst_sdat", sdat, 0);
      chk("rst_sclk", sclk, 0);
      chk("rst_latch", latch, 0);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_plane", plane, 0);
      chk("rst_frame", frame, 0);

      rst = 1'b0;
      repeat (2) tick();
      chk("idle_oe_n", oe_n, 1);

      // all-zero buffer, two full frames
      enable = 1'b1;
      mon_on = 1;
      run_planes(2 * 8 * (PWM_TOP + 1), 20000);

      // drop enable during the word-7 shift of plane 3
      k = 0;
      do begin
         tick();
         k++;
      end while (!(sclk && m_plane == 3 && m_word == 8) && k < 2000);
      chk("find_p3w7", k < 2000, 1);
      enable = 1'b0;
      run_planes(1, 300);
      chk("drop_plane", m_plane, 4);
      nsclk = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sclk) nsclk++;
      end
      chk("idle_sclk", nsclk, 0);
      chk("idle_oe_n2", oe_n, 1);
      chk("idle_plane", plane, 0);

      // random buffer with boundary words in plane 0
      mon_on = 0;
      tick();
      for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
      mem[0] = '1;
      mem[1] = {8{8'h01}};
      mem[2][7:0] = 8'h80;
      mem[3] = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      mem[4] = {8'd11, 8'd10, 8'd9, 8'd8, 8'd12, 8'd0, 8'hFF, 8'hFE};
      enable = 1'b1;
      mon_on = 1;
      run_planes(8 * (PWM_TOP + 1) + 4, 9000);

      // asynchronous reset while sclk is high
      k = 0;
      do begin
         tick();
         k++;
      end while (!sclk && k < 20);
      chk("find_sh_hi", sclk, 1);
      #1 rst = 1'b1;
      enable = 1'b0;
      mon_on = 0;
      #1;
      chk("arst_sclk", sclk, 0);
      chk("arst_latch", latch, 0);
      chk("arst_plane", plane, 0);
      chk("arst_oe_n", oe_n, 1);
      chk("arst_addrb", addrb, 0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      enable = 1'b1;
      mon_on = 1;
      tick();
      chk("restart_addrb", addrb, 0);
      chk("restart_frame", frame, 1);
      run_planes(10, 1200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
